// File: rtl/viterbi_acs_ctrl_param.sv
// Framed ACS/traceback sequencer: steps a {page, segment} counter and drives Init/Hold/TB strobes.
// Optional macro VIT_CTRL_AUTO_RESTART_EN: back-to-back frames without returning to IDLE.
module viterbi_acs_ctrl_param #(
  parameter int SEG_W  = 4,
  parameter int PAGE_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_active,
  input  logic              i_start,
  input  logic [PAGE_W-1:0] i_frame_len,
  output logic [PAGE_W-1:0] o_acs_page,
  output logic [SEG_W-1:0]  o_acs_segment,
  output logic              o_init,
  output logic              o_hold,
  output logic              o_tb_en,
  output logic              o_tb_stop,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = PAGE_W + SEG_W;
  localparam logic [SEG_W-1:0] SEG_MAX = '1;
  localparam logic [SEG_W-1:0] SEG_PRE = SEG_W'((2 ** SEG_W) - 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [PAGE_W-1:0] r_last_page, w_last_page_next;
  logic              r_init, w_init_next;
  logic              r_hold, w_hold_next;
  logic              r_tb_en, w_tb_en_next;
  logic              r_tb_arm, w_tb_arm_next;
  logic              r_tb_stop, w_tb_stop_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;

  logic [PAGE_W-1:0] w_page;
  logic [SEG_W-1:0]  w_seg;
  logic              w_on_last;
  logic              w_frame_end;

  assign w_page    = r_cnt[CNT_W-1:SEG_W];
  assign w_seg     = r_cnt[SEG_W-1:0];
  assign w_on_last = (w_page == r_last_page);
  // Qualifying with tb_arm keeps the all-ones starting address from looking like
  // the final address when LastPage is all ones.
  assign w_frame_end = r_tb_arm && w_on_last && (w_seg == SEG_MAX);

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_last_page_next = r_last_page;
    w_init_next      = r_init;
    w_hold_next      = r_hold;
    w_tb_en_next     = r_tb_en;
    w_tb_arm_next    = r_tb_arm;
    w_tb_stop_next   = r_tb_stop;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_last_page_next = i_frame_len;
          w_cnt_next       = '1;
          w_tb_en_next     = 1'b0;
          w_tb_arm_next    = 1'b0;
          w_tb_stop_next   = 1'b0;
          w_init_next      = 1'b0;
          w_hold_next      = 1'b0;
          w_busy_next      = 1'b1;
          w_state_next     = S_RUN;
        end
      end
      S_RUN: begin
        if (i_active) begin
          w_cnt_next     = r_cnt + CNT_W'(1);
          w_init_next    = (w_seg == SEG_MAX);
          w_hold_next    = (w_seg == SEG_PRE);
          w_tb_en_next   = r_tb_arm;
          w_tb_stop_next = w_on_last;
          if ((w_seg == SEG_PRE) && w_on_last) begin
            w_tb_arm_next = 1'b1;
          end
          if (w_frame_end) begin
            w_cnt_next  = '1;
            w_done_next = 1'b1;
`ifdef VIT_CTRL_AUTO_RESTART_EN
            w_last_page_next = i_frame_len;
            w_tb_arm_next    = 1'b0;
            w_tb_en_next     = 1'b0;
`else
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
`endif
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '1;
      r_last_page <= '1;
      r_init      <= 1'b0;
      r_hold      <= 1'b0;
      r_tb_en     <= 1'b0;
      r_tb_arm    <= 1'b0;
      r_tb_stop   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_last_page <= w_last_page_next;
      r_init      <= w_init_next;
      r_hold      <= w_hold_next;
      r_tb_en     <= w_tb_en_next;
      r_tb_arm    <= w_tb_arm_next;
      r_tb_stop   <= w_tb_stop_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  assign o_acs_page    = w_page;
  assign o_acs_segment = w_seg;
  assign o_init        = r_init;
  assign o_hold        = r_hold;
  assign o_tb_en       = r_tb_en;
  assign o_tb_stop     = r_tb_stop;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
